// File: rtl/lsu_mem_master.sv
// Load/store initiator for a 64-bit word data memory with a 1-cycle registered read.
// Sub-doubleword stores are done as read-modify-write; misaligned requests complete without memory access.
module lsu_mem_master #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [2:0]          r_off;
    logic [63:0]         r_wdata;
    logic [TAG_W-1:0]    r_tag;
    logic                r_resp_valid;
    logic [63:0]         r_resp_rdata;
    logic [TAG_W-1:0]    r_resp_tag;
    logic                r_resp_mis;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [63:0]         r_mem_wdata;

    logic [5:0]          w_shamt;
    logic [63:0]         w_mask;
    logic [63:0]         w_rshift;
    logic                w_sign;
    logic [63:0]         w_load;
    logic [63:0]         w_merged;
    logic [ADDR_W-1:0]   w_aligned;
    logic                w_misaligned;

    // Field mask in bit 0 position; the sign bit is the top set bit of the mask.
    always_comb begin
        w_shamt = {r_off, 3'b000};
        case (r_size)
            2'd0:    w_mask = 64'h0000_0000_0000_00FF;
            2'd1:    w_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    w_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_mask = '1;
        endcase
        w_rshift     = mem_rdata >> w_shamt;
        w_sign       = ~r_unsigned & (|(w_rshift & (w_mask ^ (w_mask >> 1))));
        w_load       = w_sign ? (w_rshift | ~w_mask) : (w_rshift & w_mask);
        w_merged     = (mem_rdata & ~(w_mask << w_shamt)) | ((r_wdata & w_mask) << w_shamt);
        w_aligned    = {req_addr[ADDR_W-1:3], 3'b000};
        w_misaligned = ((req_size == 2'd1) &&   req_addr[0])     ||
                       ((req_size == 2'd2) && (|req_addr[1:0])) ||
                       ((req_size == 2'd3) && (|req_addr[2:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_off        <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_tag   <= '0;
            r_resp_mis   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_off       <= req_addr[2:0];
                        r_wdata     <= req_wdata;
                        r_tag       <= req_tag;
                        if (w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_mis   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_tag   <= req_tag;
                        end else if (req_we && (req_size == 2'd3)) begin
                            r_state     <= S_WR;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= w_aligned;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state    <= S_RD;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_aligned;
                        end
                    end
                end
                S_RD: begin
                    r_state    <= S_CAP;
                    r_mem_read <= 1'b0;
                end
                // mem_rdata is only valid in this cycle, so both the load result and the merge are taken here.
                S_CAP: begin
                    if (r_we) begin
                        r_state     <= S_WR;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_state      <= S_RESP;
                        r_mem_addr   <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                        r_resp_tag   <= r_tag;
                    end
                end
                S_WR: begin
                    r_state      <= S_RESP;
                    r_mem_write  <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_tag   <= r_tag;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_tag   <= '0;
                    r_resp_mis   <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_tag        = r_resp_tag;
    assign resp_misaligned = r_resp_mis;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator between the pipeline's memory stage and the 64-bit word data memory. The data memory has a 1-cycle registered read and no byte enables.
- Accepts one load or store request at a time and issues the memory read/write strobes.
- For loads, captures the returned doubleword, then extracts and sign- or zero-extends the addressed field.
- Performs sub-doubleword stores as read-modify-write.
- Flags misaligned accesses without touching memory.

Parameters:
ADDR_W, 64, request/memory address width
TAG_W, 5, destination-register tag width carried request->response

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=dword
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, field in low bits
req_tag  in  TAG_W  destination tag
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load data; 0 for stores/misaligned
resp_tag  out  TAG_W  tag of completed request
resp_misaligned  out  1  completion was an alignment fault
mem_read  out  1  read strobe to data memory
mem_write  out  1  write strobe to data memory
mem_addr  out  ADDR_W  doubleword-aligned address {addr[ADDR_W-1:3],3'b000}
mem_wdata  out  64  full doubleword to write
mem_rdata  in  64  memory read data, valid the cycle after mem_read

Behaviour:
- Reset (rst=1 at rising edge):
  - Next state IDLE.
  - All outputs 0 except req_ready=1.
  - Latched request registers cleared.
  - Reset mid-operation abandons the access with no response; any write strobe already issued is not retracted.
- Request acceptance and memory outputs:
  - A request is accepted on the edge where req_valid && req_ready.
  - All req_* fields are latched at acceptance.
  - mem_* outputs decode only from the state register and latched fields; there is no combinational path from req_* to mem_*.
- States: IDLE, RD, CAP, WR, RESP.
- Misaligned check at acceptance:
  - half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0; byte is always aligned.
  - Misaligned: IDLE->RESP with misaligned=1 and no mem strobe.
- Load: IDLE->RD->CAP->RESP->IDLE.
  - RD: mem_read=1.
  - CAP: sample mem_rdata (memory returns 0 if not read the prior cycle, so the sample must occur exactly here). Extract the field at byte offset o=addr[2:0], little-endian: byte k = bits[8k+7:8k]. Extend to 64 bits per req_unsigned and register it into resp_rdata.
- Dword store: IDLE->WR->RESP.
  - WR: mem_write=1, mem_wdata=req_wdata.
- Sub-dword store: IDLE->RD->CAP->WR->RESP.
  - CAP: merged = mem_rdata with the size-wide field at offset o replaced by the low bits of req_wdata; registered.
  - WR: mem_write=1, mem_wdata=merged.
- RESP: resp_valid=1 for exactly one cycle with resp_tag, resp_rdata and resp_misaligned.
  - resp_rdata is 0 for stores and misaligned accesses.
  - Next state IDLE.
- Completion latency (accept edge T, resp_valid high during cycle):
  - misaligned: T+1
  - dword store: T+2
  - load: T+3
  - sub-dword store: T+4
- Response flow control:
  - No back-pressure on responses.
  - req_ready=0 in every state except IDLE, so new requests stall until the prior one completes.
  - A request is not accepted during the RESP cycle.
- mem_read and mem_write are never high in the same cycle.
- mem_addr holds the latched aligned address in RD/CAP/WR; it is 0 in IDLE.

Test Plan:
1. Dword store addr=0x10, wdata=0x1122334455667788; then dword load addr=0x10 -> mem_write in one cycle with mem_addr=0x10. resp_valid at T+2 for the store and T+3 for the load, with rdata=0x1122334455667788.
2. Byte store 0xAB at addr=0x13 over memory word 0x1122334455667788 -> one RD cycle then a WR cycle with mem_wdata=0x11223344AB667788. resp_valid at T+4.
3. Memory word 0x00000000_8000F0FF at 0x20 -> signed byte load addr 0x20 gives 0xFFFFFFFFFFFFFFFF. Unsigned half load addr 0x20 gives 0xF0FF. Signed word load addr 0x20 gives 0xFFFFFFFF8000F0FF.
4. Word load addr=0x22 -> resp_valid at T+1, resp_misaligned=1, rdata=0, no mem_read/mem_write asserted.
5. req_valid held high with back-to-back requests -> req_ready low from accept until after RESP. Tags returned in order. mem_read and mem_write never both high.
6. rst=1 during the CAP cycle of a sub-dword store -> no mem_write and no resp_valid. Next cycle req_ready=1 and all outputs 0. The stored word is unchanged.
